decode_pipe_reg: RTL and testbench

DECODE_PIPE_REG -- requirements
Module: decode_pipe_reg

---
 rtl/decode_pipe_reg.sv | 111 +++++++++++
 tb/tb_decode_pipe_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_reg.sv
// Decode-to-execute pipeline register with load-use interlock, halt state,
// sticky decode-error flag and a saturating load-use bubble counter.
module decode_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 24,
    parameter int AW     = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] rd1_data,
    input  logic [DATA_W-1:0] rd2_data,
    input  logic [AW-1:0]     rd1_sel,
    input  logic [AW-1:0]     rd2_sel,
    input  logic              uses_rd2,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [AW-1:0]     wreg_in,
    input  logic              regwrt_in,
    input  logic              memrd_in,
    input  logic              halt_in,
    input  logic              err_in,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_instr,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [AW-1:0]     ex_wreg,
    output logic              ex_regwrt,
    output logic              ex_memrd,
    output logic              ex_halt,
    output logic              stall_out,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t stateQ, stateD;
    logic   loadUse;
    logic   doBubble;
    logic   doCapture;
    logic   capHalt;

    // Priority below rst: flush > stall_in > loadUse > HALTED > capture.
    always_comb begin
        loadUse   = if_valid & ex_valid & ex_memrd & ex_regwrt &
                    ((ex_wreg == rd1_sel) | (uses_rd2 & (ex_wreg == rd2_sel)));
        stall_out = stall_in | loadUse | (stateQ == HALTED);
        doBubble  = flush | (~stall_in & (loadUse | (stateQ == HALTED)));
        doCapture = ~flush & ~stall_in & ~loadUse & (stateQ == RUN);
        capHalt   = if_valid & halt_in & (if_pc != '0);
        stateD    = stateQ;
        if (flush)
            stateD = RUN;
        else if (doCapture && capHalt)
            stateD = HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stateQ <= RUN;
        else
            stateQ <= stateD;
    end

    always_ff @(posedge clk) begin
        if (rst || doBubble) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_instr  <= '0;
            ex_rd1    <= '0;
            ex_rd2    <= '0;
            ex_ctrl   <= '0;
            ex_wreg   <= '0;
            ex_regwrt <= 1'b0;
            ex_memrd  <= 1'b0;
            ex_halt   <= 1'b0;
        end else if (doCapture) begin
            ex_valid  <= if_valid;
            ex_pc     <= if_pc;
            ex_instr  <= if_instr;
            ex_rd1    <= rd1_data;
            ex_rd2    <= rd2_data;
            ex_ctrl   <= ctrl_in;
            ex_wreg   <= wreg_in;
            ex_regwrt <= regwrt_in;
            ex_memrd  <= memrd_in;
            ex_halt   <= capHalt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            if (doCapture && if_valid && err_in)
                err_sticky <= 1'b1;
            // Counted only when the interlock actually inserts the bubble.
            if (!flush && !stall_in && loadUse && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Directed and randomized bench for decode_pipe_reg against a behavioural model.
module tb_decode_pipe_reg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 24;
    localparam int AW     = 3;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, stall_in, flush, if_valid, uses_rd2;
    logic [DATA_W-1:0] if_pc, if_instr, rd1_data, rd2_data;
    logic [AW-1:0]     rd1_sel, rd2_sel, wreg_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              regwrt_in, memrd_in, halt_in, err_in;
    logic              ex_valid, ex_regwrt, ex_memrd, ex_halt, stall_out, err_sticky;
    logic [DATA_W-1:0] ex_pc, ex_instr, ex_rd1, ex_rd2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [AW-1:0]     ex_wreg;
    logic [CNT_W-1:0]  bubble_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit checkOn = 0;

    always #5 clk = ~clk;

    decode_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
        .uses_rd2(uses_rd2), .ctrl_in(ctrl_in), .wreg_in(wreg_in),
        .regwrt_in(regwrt_in), .memrd_in(memrd_in), .halt_in(halt_in), .err_in(err_in),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg), .ex_regwrt(ex_regwrt),
        .ex_memrd(ex_memrd), .ex_halt(ex_halt), .stall_out(stall_out),
        .err_sticky(err_sticky), .bubble_cnt(bubble_cnt)
    );

    // Behavioural model: one record for the EX slot plus plain status variables.
    typedef struct {
        bit valid; int pc; int instr; int rd1; int rd2; int ctrl;
        int wreg; bit regwrt; bit memrd; bit halt;
    } exRec_t;

    exRec_t mEx = '{default: 0};
    bit mHalted = 0;
    bit mErr = 0;
    int mCnt = 0;

    function automatic bit modelLoadUse();
        if (!(if_valid && mEx.valid && mEx.memrd && mEx.regwrt)) return 0;
        return (mEx.wreg == int'(rd1_sel)) || (uses_rd2 && mEx.wreg == int'(rd2_sel));
    endfunction

    always @(posedge clk) begin
        exRec_t empty;
        bit lu;
        empty = '{default: 0};
        lu = modelLoadUse();
        if (rst) begin
            mEx = empty; mHalted = 0; mErr = 0; mCnt = 0;
        end else if (flush) begin
            mEx = empty; mHalted = 0;
        end else if (stall_in) begin
            // hold everything
        end else if (lu) begin
            mEx = empty;
            if (mCnt < CNT_MAX) mCnt++;
        end else if (mHalted) begin
            mEx = empty;
        end else begin
            mEx.valid = if_valid;  mEx.pc = int'(if_pc);  mEx.instr = int'(if_instr);
            mEx.rd1 = int'(rd1_data); mEx.rd2 = int'(rd2_data); mEx.ctrl = int'(ctrl_in);
            mEx.wreg = int'(wreg_in); mEx.regwrt = regwrt_in; mEx.memrd = memrd_in;
            mEx.halt = if_valid && halt_in && (if_pc != 0);
            if (mEx.halt) mHalted = 1;
            if (if_valid && err_in) mErr = 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            chk("ex_valid",   32'(ex_valid),   32'(mEx.valid));
            chk("ex_pc",      32'(ex_pc),      mEx.pc);
            chk("ex_instr",   32'(ex_instr),   mEx.instr);
            chk("ex_rd1",     32'(ex_rd1),     mEx.rd1);
            chk("ex_rd2",     32'(ex_rd2),     mEx.rd2);
            chk("ex_ctrl",    32'(ex_ctrl),    mEx.ctrl);
            chk("ex_wreg",    32'(ex_wreg),    mEx.wreg);
            chk("ex_regwrt",  32'(ex_regwrt),  32'(mEx.regwrt));
            chk("ex_memrd",   32'(ex_memrd),   32'(mEx.memrd));
            chk("ex_halt",    32'(ex_halt),    32'(mEx.halt));
            chk("err_sticky", 32'(err_sticky), 32'(mErr));
            chk("bubble_cnt", 32'(bubble_cnt), mCnt);
            chk("stall_out",  32'(stall_out),  32'(stall_in || modelLoadUse() || mHalted));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stall_in = 0; flush = 0; if_valid = 0; uses_rd2 = 0;
        if_pc = '0; if_instr = '0; rd1_data = '0; rd2_data = '0;
        rd1_sel = '0; rd2_sel = '0; wreg_in = '0; ctrl_in = '0;
        regwrt_in = 0; memrd_in = 0; halt_in = 0; err_in = 0;
    endtask

    task automatic presentLoadUse();
        if_valid = 1; memrd_in = 1; regwrt_in = 1; wreg_in = 3'd2; rd1_sel = 3'd2;
        if_pc = 16'h0100;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        rst = 0;
        chk("rst ex_valid", 32'(ex_valid), 0);
        chk("rst bubble_cnt", 32'(bubble_cnt), 0);
        chk("rst err_sticky", 32'(err_sticky), 0);
        chk("rst stall_out", 32'(stall_out), 0);
        checkOn = 1;

        // capture
        if_valid = 1; if_pc = 16'h0012; if_instr = 16'hC123; ctrl_in = 24'h00ABCD; wreg_in = 3'd3;
        tick();
        chk("cap ex_valid", 32'(ex_valid), 1);
        chk("cap ex_pc", 32'(ex_pc), 32'h12);
        chk("cap ex_instr", 32'(ex_instr), 32'hC123);
        chk("cap ex_ctrl", 32'(ex_ctrl), 32'hABCD);
        chk("cap ex_wreg", 32'(ex_wreg), 3);

        // load-use
        idle(); if_valid = 1; memrd_in = 1; regwrt_in = 1; wreg_in = 3'd2; if_pc = 16'h0020;
        tick();
        idle(); if_valid = 1; rd1_sel = 3'd2; wreg_in = 3'd5; if_pc = 16'h0022; ctrl_in = 24'h000111;
        #1;
        chk("lu stall_out", 32'(stall_out), 1);
        tick();
        chk("lu ex_valid", 32'(ex_valid), 0);
        chk("lu ex_ctrl", 32'(ex_ctrl), 0);
        chk("lu bubble_cnt", 32'(bubble_cnt), 1);
        tick();
        chk("lu recap valid", 32'(ex_valid), 1);
        chk("lu recap pc", 32'(ex_pc), 32'h22);

        // hold, then flush beating stall
        stall_in = 1; if_pc = 16'h0040;
        repeat (3) tick();
        chk("hold ex_pc", 32'(ex_pc), 32'h22);
        chk("hold ex_valid", 32'(ex_valid), 1);
        flush = 1;
        tick();
        chk("flush ex_valid", 32'(ex_valid), 0);
        idle();

        // halt with nonzero pc
        if_valid = 1; halt_in = 1; if_pc = 16'h0002;
        tick();
        chk("halt ex_halt", 32'(ex_halt), 1);
        halt_in = 0; if_pc = 16'h0004;
        #1;
        chk("halt stall_out", 32'(stall_out), 1);
        tick();
        chk("halt bubble1", 32'(ex_valid), 0);
        tick();
        chk("halt bubble2", 32'(ex_valid), 0);
        chk("halt stall2", 32'(stall_out), 1);
        flush = 1;
        tick();
        flush = 0;
        tick();
        chk("unhalt ex_pc", 32'(ex_pc), 32'h4);
        // halt with zero pc stays in RUN
        halt_in = 1; if_pc = 16'h0000;
        tick();
        chk("halt0 ex_halt", 32'(ex_halt), 0);
        halt_in = 0; if_pc = 16'h0006;
        tick();
        chk("halt0 run", 32'(ex_pc), 32'h6);

        // sticky error
        err_in = 1;
        tick();
        err_in = 0;
        repeat (12) tick();
        chk("err sticky", 32'(err_sticky), 1);

        // saturation: each load-use takes a capture cycle and a bubble cycle
        idle(); presentLoadUse();
        repeat (600) tick();
        chk("cnt saturate", 32'(bubble_cnt), 255);

        // reset while halted with error and five bubbles
        idle(); rst = 1;
        tick();
        idle(); presentLoadUse();
        repeat (10) tick();
        idle(); if_valid = 1; err_in = 1; halt_in = 1; if_pc = 16'h0008;
        tick();
        idle();
        tick();
        chk("pre-rst cnt", 32'(bubble_cnt), 5);
        chk("pre-rst err", 32'(err_sticky), 1);
        chk("pre-rst halted", 32'(stall_out), 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rst2 ex_halt", 32'(ex_halt), 0);
        chk("rst2 err", 32'(err_sticky), 0);
        chk("rst2 cnt", 32'(bubble_cnt), 0);
        chk("rst2 stall_out", 32'(stall_out), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(99) < 2);
            flush     = ($urandom_range(99) < 3);
            stall_in  = ($urandom_range(99) < 15);
            if_valid  = ($urandom_range(99) < 80);
            if_pc     = ($urandom_range(3) == 0) ? '0 : DATA_W'($urandom);
            if_instr  = DATA_W'($urandom);
            rd1_data  = DATA_W'($urandom);
            rd2_data  = DATA_W'($urandom);
            ctrl_in   = CTRL_W'($urandom);
            rd1_sel   = AW'($urandom);
            rd2_sel   = AW'($urandom);
            wreg_in   = AW'($urandom);
            uses_rd2  = 1'($urandom);
            regwrt_in = ($urandom_range(99) < 60);
            memrd_in  = ($urandom_range(99) < 40);
            halt_in   = ($urandom_range(99) < 4);
            err_in    = ($urandom_range(99) < 3);
            tick();
        end

        checkOn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
